// File: rtl/uart_tx_arbiter_if.sv
// Request-side and transmitter-side handshake bundle for uart_tx_arbiter.
// Latency: none (wires only).
// Backpressure: req_ready and uart_ready are the only stall signals carried here.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           uart_data;
    logic                 uart_valid;
    logic                 uart_ready;

    // Producer/transmitter environment side
    modport master (
        output req_data, req_valid, req_last, uart_ready,
        input  req_ready, uart_data, uart_valid
    );

    // Arbiter side
    modport slave (
        input  req_data, req_valid, req_last, uart_ready,
        output req_ready, uart_data, uart_valid
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter feeding NUM_REQ byte sources into one UART transmitter.
// Latency: grant one cycle after a request is seen in IDLE; byte reaches uart_data one cycle after its handshake.
// Backpressure: one byte per transmitter frame; stalls indefinitely on uart_ready low or granted source idle.
// Optional macro UART_ARB_HDR_EN prefixes each packet with header byte HDR_BASE | grant_id.
module uart_tx_arbiter #(
    parameter int          NUM_REQ  = 4,
    parameter logic [7:0]  HDR_BASE = 8'hA0,
    localparam int         GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_tx_arbiter_if.slave    bus,
    output logic                busy,
    output logic [GW-1:0]       grant_id
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] FETCH     = 3'd2;
    localparam logic [2:0] ISSUE     = 3'd3;
    localparam logic [2:0] WAIT_BUSY = 3'd4;
    localparam logic [2:0] WAIT_DONE = 3'd5;
`ifdef UART_ARB_HDR_EN
    localparam logic [2:0] HDR       = 3'd1;
`endif

    // Elaboration-time parameter sanity
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end
    if (HDR_BASE[2:0] != 3'b000) begin : g_bad_hdr_base
        $error("HDR_BASE low 3 bits must be zero");
    end

    logic [2:0]    state;
    logic [GW-1:0] last_grant;
    logic          last_q;
    logic [GW-1:0] pick;
    logic          any_req;
    int            best_d;
    int            d;

    // Round-robin pick: smallest rotational distance from last_grant+1 among valid requesters
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        best_d  = NUM_REQ;
        d       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = (i + NUM_REQ - 1 - int'(last_grant)) % NUM_REQ;
            if (bus.req_valid[i] && d < best_d) begin
                best_d  = d;
                pick    = GW'(i);
                any_req = 1'b1;
            end
        end
    end

    // Only the granted requester is offered ready, and only while fetching
    always_comb begin
        bus.req_ready = '0;
        if (state == FETCH) begin
            bus.req_ready[grant_id] = bus.req_valid[grant_id];
        end
    end

    // Packet sequencer: grant, fetch a byte, issue it, wait out the frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_grant     <= GW'(NUM_REQ - 1);
            last_q         <= 1'b0;
            busy           <= 1'b0;
            grant_id       <= '0;
            bus.uart_data  <= 8'h00;
            bus.uart_valid <= 1'b0;
        end else begin
            bus.uart_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id <= pick;
                        busy     <= 1'b1;
`ifdef UART_ARB_HDR_EN
                        state    <= HDR;
`else
                        state    <= FETCH;
`endif
                    end
                end
`ifdef UART_ARB_HDR_EN
                HDR: begin
                    bus.uart_data <= HDR_BASE | {{(8-GW){1'b0}}, grant_id};
                    last_q        <= 1'b0;
                    state         <= ISSUE;
                end
`endif
                FETCH: begin
                    if (bus.req_valid[grant_id]) begin
                        bus.uart_data <= bus.req_data[grant_id*8 +: 8];
                        last_q        <= bus.req_last[grant_id];
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.uart_ready) begin
                        bus.uart_valid <= 1'b1;
                        state          <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (!bus.uart_ready) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (bus.uart_ready) begin
                        if (last_q) begin
                            last_grant <= grant_id;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            state      <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
